// File: rtl/core_pkg.sv
// Shared pipeline-control types and constants for the 5-stage core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    // Sequencing controller states; encoding is fixed for debug visibility.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEMWAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // x0 is hardwired to zero, so it never carries a load-use dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // ID/EX control bundle; a bubble is every control bit cleared.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [3:0] alu_op;
    } idex_ctrl_t;

    localparam idex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard inputs and stage-register enable/flush controls.
// Latency: n/a (wiring only).
// Backpressure: the controls themselves are the pipeline's stall mechanism.
interface hazard_stall_ctrl_if;
    logic [4:0] IFIDrs1;
    logic [4:0] IFIDrs2;
    logic       IFIDUsesRs1;
    logic       IFIDUsesRs2;
    logic [4:0] IDEXrd;
    logic       IDEXMemRead;
    logic       EXRedirect;
    logic       MemReq;
    logic       MemReady;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IFIDFlush;
    logic       IDEXWrite;
    logic       IDEXFlush;
    logic       EXMEMWrite;

    // Pipeline side: reports hazard sources, consumes controls.
    modport master (
        output IFIDrs1, IFIDrs2, IFIDUsesRs1, IFIDUsesRs2, IDEXrd, IDEXMemRead,
        output EXRedirect, MemReq, MemReady,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite
    );

    // Controller side.
    modport slave (
        input  IFIDrs1, IFIDrs2, IFIDUsesRs1, IFIDUsesRs2, IDEXrd, IDEXMemRead,
        input  EXRedirect, MemReq, MemReady,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite
    );
endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use comparator: ID source registers against the load destination in EX.
// Latency: purely combinational.
// Backpressure: none; the result feeds the stall controller.
module hazard_detect
    import core_pkg::*;
(
    input  logic [4:0] IFIDrs1,
    input  logic [4:0] IFIDrs2,
    input  logic       IFIDUsesRs1,
    input  logic       IFIDUsesRs2,
    input  logic [4:0] IDEXrd,
    input  logic       IDEXMemRead,
    output logic       loaduse
);

    logic rs1_hit;
    logic rs2_hit;

    // Only sources the ID instruction actually reads can create a dependency.
    assign rs1_hit = IFIDUsesRs1 && (IFIDrs1 == IDEXrd);
    assign rs2_hit = IFIDUsesRs2 && (IFIDrs2 == IDEXrd);
    assign loaduse = IDEXMemRead && (IDEXrd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use bubbles, redirect squashing, memory-wait freeze.
// Latency: controls are combinational in the triggering cycle; state updates next CLK.
// Backpressure: MemReq without MemReady freezes every stage register.
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int FLUSH_EXTRA = 0,
    parameter int MEM_TIMEOUT = 255,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    hazard_stall_ctrl_if.slave     pif,
    output logic [STALL_CNT_W-1:0] StallCycles,
    output logic                   MemTimeout
);

    localparam int               WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_EXTRA);

    state_t            state_q, state_d;
    logic [2:0]        flush_q, flush_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_set;
    logic              memstall;
    logic              loaduse;

    logic pc_wr, ifid_wr, ifid_fl, idex_wr, idex_fl, exmem_wr;

    hazard_detect u_hazard_detect (
        .IFIDrs1     (pif.IFIDrs1),
        .IFIDrs2     (pif.IFIDrs2),
        .IFIDUsesRs1 (pif.IFIDUsesRs1),
        .IFIDUsesRs2 (pif.IFIDUsesRs2),
        .IDEXrd      (pif.IDEXrd),
        .IDEXMemRead (pif.IDEXMemRead),
        .loaduse     (loaduse)
    );

    assign memstall = pif.MemReq && !pif.MemReady;

    // Next-state and stage controls; memory freeze outranks everything, a
    // redirect outranks a load-use (the ID instruction is on the wrong path).
    always_comb begin
        pc_wr       = 1'b1;
        ifid_wr     = 1'b1;
        ifid_fl     = 1'b0;
        idex_wr     = 1'b1;
        idex_fl     = 1'b0;
        exmem_wr    = 1'b1;
        state_d     = state_q;
        flush_d     = flush_q;
        wait_d      = wait_q;
        timeout_set = 1'b0;

        if (RST) begin
            pc_wr    = 1'b0;
            ifid_wr  = 1'b0;
            ifid_fl  = 1'b1;
            idex_wr  = 1'b0;
            idex_fl  = 1'b1;
            exmem_wr = 1'b0;
        end else begin
            case (state_q)
                RUN, MEMWAIT: begin
                    if (memstall) begin
                        // EX is frozen too, so a pending redirect simply waits.
                        pc_wr    = 1'b0;
                        ifid_wr  = 1'b0;
                        idex_wr  = 1'b0;
                        exmem_wr = 1'b0;
                        state_d  = MEMWAIT;
                        if (state_q == RUN) begin
                            wait_d = WAIT_W'(1);
                        end else if (wait_q != WAIT_MAX) begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                        timeout_set = (wait_d == WAIT_MAX);
                    end else begin
                        wait_d  = '0;
                        state_d = RUN;
                        if (pif.EXRedirect) begin
                            ifid_fl = 1'b1;
                            idex_fl = 1'b1;
                            if (FLUSH_EXTRA > 0) begin
                                state_d = REDIRECT;
                                flush_d = FLUSH_INIT;
                            end
                        end else if (loaduse) begin
                            // One bubble clears IDEXMemRead, so the hazard self-clears.
                            pc_wr   = 1'b0;
                            ifid_wr = 1'b0;
                            idex_fl = 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (memstall) begin
                        pc_wr    = 1'b0;
                        ifid_wr  = 1'b0;
                        idex_wr  = 1'b0;
                        exmem_wr = 1'b0;
                    end else begin
                        // Keep squashing while instruction memory drains stale fetches.
                        ifid_fl = 1'b1;
                        idex_fl = 1'b1;
                        flush_d = flush_q - 3'd1;
                        wait_d  = '0;
                        if (flush_q <= 3'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign pif.PCWrite    = pc_wr;
    assign pif.IFIDWrite  = ifid_wr;
    assign pif.IFIDFlush  = ifid_fl;
    assign pif.IDEXWrite  = idex_wr;
    assign pif.IDEXFlush  = idex_fl;
    assign pif.EXMEMWrite = exmem_wr;

    // State, counters and debug flags; reset aborts any stall or redirect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            flush_q     <= '0;
            wait_q      <= '0;
            StallCycles <= '0;
            MemTimeout  <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
            if (!pc_wr && (StallCycles != '1)) begin
                StallCycles <= StallCycles + STALL_CNT_W'(1);
            end
            if (timeout_set) begin
                MemTimeout <= 1'b1;
            end
        end
    end

endmodule
